psg_register_bank: RTL
======================

// Module: psg_register_bank
// PURPOSE
//  Parametrised AY-3-891x-style PSG register file with an AY bus interface (BDIR/BC1).
//  - Channel count is configurable; the register map is generated from it.
//  - Per-field output buses feed the tone, noise, envelope and mixer datapath.
//  - Emits a one-cycle envelope restart strobe; optional register readback.
//  - Sits between the chip-top pin decode and the sound generators.
// PARAMETERS
//  NUM_CHANNELS   3   tone channels, legal range 1..4 (the mixer register holds 2*N bits)
//  TONE_BITS      12  tone period width per channel, legal range 9..12
//  NOISE_BITS     5   noise period width, legal range 1..8
//  ENV_BITS       16  envelope period width, legal range 9..16
//  ADDR_BITS      4   latched address width; 3*NUM_CHANNELS+5 must be <= 2**ADDR_BITS
// PORTS
//  clk              in   1       clock
//  reset            in   1       synchronous, active-high reset
//  bdir             in   1       bus direction
//  bc1              in   1       bus control
//  data_in          in   8       bus data
//  data_out         out  8       readback data, registered
//  data_oe          out  1       readback drive enable, registered
//  tone_period      out  N*TONE  channel c occupies [c*TONE_BITS +: TONE_BITS]
//  noise_period     out  NOISE   noise period
//  tone_disable     out  N       mixer tone-disable bits, active high, as written
//  noise_disable    out  N       mixer noise-disable bits, active high
//  amplitude        out  N*4     fixed level per channel
//  env_mode         out  N       1 = channel follows the envelope
//  envelope_period  out  ENV     envelope period
//  envelope_shape   out  4       {continue, attack, alternate, hold}
//  envelope_restart out  1       one-cycle pulse
// BEHAVIOUR
//  Bus mode {bdir,bc1}:
//  - 00 idle.
//  - 01 read.
//  - 10 write.
//  - 11 latch address: addr <= data_in[ADDR_BITS-1:0]. The new address is effective the next cycle.
//  Register map (N = NUM_CHANNELS):
//  - Tone period, channel c: low byte at 2c, high bits [TONE_BITS-9:0] at 2c+1.
//  - 2N noise period; 2N+1 mixer (bits [N-1:0] tone, [2N-1:N] noise).
//  - 2N+2+c amplitude channel c: bit4 env_mode, bits[3:0] level.
//  - 3N+2 envelope period low byte; 3N+3 envelope period high bits.
//  - 3N+4 envelope shape, bits[3:0].
//  - For N=3 this is the classic AY 0..13 map.
//  Write rules:
//  - In mode 10 every cycle writes data_in, masked to field width; unused bits are dropped.
//  - Writes to addr >= 3N+5 are ignored.
//  envelope_restart:
//  - High for exactly one cycle, the cycle after the first write cycle to 3N+4.
//  - Holding mode 10 on that address gives no extra pulses.
//  - Rewriting the same value still pulses.
//  - Leaving mode 10 and re-entering re-arms the strobe.
//  Read (mode 01): data_out/data_oe update one cycle after the sample.
//  - data_oe = 1 while in read mode.
//  - data_out = field zero-extended to 8 bits; 0 for unmapped addresses.
//  Reset: all fields, addr, data_out, data_oe and envelope_restart go to 0.
//  - Reset in the same cycle as a write: reset wins, no write, no strobe.
//  Mode transitions: switching directly from 11 to 10 in consecutive cycles writes using the newly latched address.
// CONFIGURATION
//  READBACK_EN
//  - Defined: read mode behaves as above.
//  - Undefined: data_out = 0 and data_oe = 0 constantly, and the read mux is not built.
// STRUCTURE
//  Package psg_pkg:
//  - Bus mode localparams MODE_IDLE/READ/WRITE/LATCH.
//  - Register-index functions reg_tone_lo(c), reg_tone_hi(c), reg_noise, reg_mixer, reg_amp(c), reg_env_lo, reg_env_hi, reg_shape, all parameterised by N.
//  Sub-module psg_bus_decoder:
//  - Registers the previous mode.
//  - Outputs latch_stb, write_en, write_first (first cycle of a write burst) and read_en.
// TESTING
//  1. Reset: assert reset 2 cycles -> every output is 0, including data_oe and envelope_restart.
//  2. Latch 0x00, write 0xAB; latch 0x01, write 0xFF -> tone_period[11:0] = 0xFAB (upper nibble masked).
//  3. Latch 0x0D, hold write 0x0E for 4 cycles -> envelope_shape = 4'hE, envelope_restart high exactly 1 cycle.
//  4. Latch 0x07, write 0x2A -> tone_disable = 3'b010, noise_disable = 3'b101.
//  5. READBACK_EN: after test 2, latch 0x01, read -> data_out = 0x0F, data_oe = 1 one cycle later; latch 0x0F, read -> data_out = 0x00.
//  6. N=4: latch 0x11 (3N+5 = 17, unmapped), write 0x55 -> no output changes.
//     Then latch 0x10 (shape), write 0x09 -> envelope_shape = 4'h9 plus restart pulse.

Source files
------------

// File: rtl/psg_pkg.sv
// Shared definitions for the PSG register bank: AY bus modes and the register
// index map, which is generated from the channel count.
package psg_pkg;

    localparam logic [1:0] MODE_IDLE  = 2'b00;
    localparam logic [1:0] MODE_READ  = 2'b01;
    localparam logic [1:0] MODE_WRITE = 2'b10;
    localparam logic [1:0] MODE_LATCH = 2'b11;

    // Tone registers sit at the bottom of the map, two per channel.
    function automatic int reg_tone_lo(input int c);
        return 2 * c;
    endfunction

    function automatic int reg_tone_hi(input int c);
        return 2 * c + 1;
    endfunction

    function automatic int reg_noise(input int n);
        return 2 * n;
    endfunction

    function automatic int reg_mixer(input int n);
        return 2 * n + 1;
    endfunction

    function automatic int reg_amp(input int n, input int c);
        return 2 * n + 2 + c;
    endfunction

    function automatic int reg_env_lo(input int n);
        return 3 * n + 2;
    endfunction

    function automatic int reg_env_hi(input int n);
        return 3 * n + 3;
    endfunction

    function automatic int reg_shape(input int n);
        return 3 * n + 4;
    endfunction

endpackage

// File: rtl/psg_bus_decoder.sv
// Decodes the AY BDIR/BC1 bus mode into latch/write/read enables and flags the
// first cycle of each write burst. Read enable exists only with READBACK_EN.
module psg_bus_decoder
    import psg_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic bdir,
    input  logic bc1,
    output logic latch_stb,
    output logic write_en,
`ifdef READBACK_EN
    output logic read_en,
`endif
    output logic write_first
);

    logic [1:0] mode;
    logic [1:0] prev_mode_reg;

    assign mode = {bdir, bc1};

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_mode_reg <= MODE_IDLE;
        end else begin
            prev_mode_reg <= mode;
        end
    end

    assign latch_stb   = (mode == MODE_LATCH);
    assign write_en    = (mode == MODE_WRITE);
    // A burst only re-arms after the bus has left write mode for at least a cycle.
    assign write_first = (mode == MODE_WRITE) && (prev_mode_reg != MODE_WRITE);
`ifdef READBACK_EN
    assign read_en     = (mode == MODE_READ);
`endif

endmodule

// File: rtl/psg_register_bank.sv
// AY-3-891x-style PSG register file with channel-count-generated register map.
// Optional register readback is built only when READBACK_EN is defined.
module psg_register_bank
    import psg_pkg::*;
#(
    parameter int NUM_CHANNELS = 3,
    parameter int TONE_BITS    = 12,
    parameter int NOISE_BITS   = 5,
    parameter int ENV_BITS     = 16,
    parameter int ADDR_BITS    = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              bdir,
    input  logic                              bc1,
    input  logic [7:0]                        data_in,
    output logic [7:0]                        data_out,
    output logic                              data_oe,
    output logic [NUM_CHANNELS*TONE_BITS-1:0] tone_period,
    output logic [NOISE_BITS-1:0]             noise_period,
    output logic [NUM_CHANNELS-1:0]           tone_disable,
    output logic [NUM_CHANNELS-1:0]           noise_disable,
    output logic [NUM_CHANNELS*4-1:0]         amplitude,
    output logic [NUM_CHANNELS-1:0]           env_mode,
    output logic [ENV_BITS-1:0]               envelope_period,
    output logic [3:0]                        envelope_shape,
    output logic                              envelope_restart
);

    localparam int N = NUM_CHANNELS;
    localparam logic [ADDR_BITS-1:0] A_NOISE  = ADDR_BITS'(reg_noise(N));
    localparam logic [ADDR_BITS-1:0] A_MIXER  = ADDR_BITS'(reg_mixer(N));
    localparam logic [ADDR_BITS-1:0] A_ENV_LO = ADDR_BITS'(reg_env_lo(N));
    localparam logic [ADDR_BITS-1:0] A_ENV_HI = ADDR_BITS'(reg_env_hi(N));
    localparam logic [ADDR_BITS-1:0] A_SHAPE  = ADDR_BITS'(reg_shape(N));

    logic latch_stb;
    logic write_en;
    logic write_first;
`ifdef READBACK_EN
    logic read_en;
`endif

    psg_bus_decoder u_decoder (
        .clk         (clk),
        .reset       (reset),
        .bdir        (bdir),
        .bc1         (bc1),
        .latch_stb   (latch_stb),
        .write_en    (write_en),
`ifdef READBACK_EN
        .read_en     (read_en),
`endif
        .write_first (write_first)
    );

    logic [ADDR_BITS-1:0]  addr_reg;
    logic [NOISE_BITS-1:0] noise_reg;
    logic [2*N-1:0]        mixer_reg;
    logic [ENV_BITS-1:0]   env_reg;
    logic [3:0]            shape_reg;
    logic                  restart_reg;

`ifdef READBACK_EN
    logic [TONE_BITS-1:0] tone_q [N];
    logic [4:0]           amp_q  [N];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_reg    <= '0;
            noise_reg   <= '0;
            mixer_reg   <= '0;
            env_reg     <= '0;
            shape_reg   <= '0;
            restart_reg <= 1'b0;
        end else begin
            if (latch_stb) begin
                addr_reg <= data_in[ADDR_BITS-1:0];
            end
            if (write_en) begin
                if (addr_reg == A_NOISE)  noise_reg              <= data_in[NOISE_BITS-1:0];
                if (addr_reg == A_MIXER)  mixer_reg              <= data_in[2*N-1:0];
                if (addr_reg == A_ENV_LO) env_reg[7:0]           <= data_in;
                if (addr_reg == A_ENV_HI) env_reg[ENV_BITS-1:8]  <= data_in[ENV_BITS-9:0];
                if (addr_reg == A_SHAPE)  shape_reg              <= data_in[3:0];
            end
            restart_reg <= write_first && (addr_reg == A_SHAPE);
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_ch
        localparam logic [ADDR_BITS-1:0] A_LO  = ADDR_BITS'(reg_tone_lo(gi));
        localparam logic [ADDR_BITS-1:0] A_HI  = ADDR_BITS'(reg_tone_hi(gi));
        localparam logic [ADDR_BITS-1:0] A_AMP = ADDR_BITS'(reg_amp(N, gi));

        logic [TONE_BITS-1:0] tone_reg;
        logic [4:0]           amp_reg;

        always_ff @(posedge clk) begin
            if (reset) begin
                tone_reg <= '0;
                amp_reg  <= '0;
            end else if (write_en) begin
                if (addr_reg == A_LO)  tone_reg[7:0]           <= data_in;
                if (addr_reg == A_HI)  tone_reg[TONE_BITS-1:8] <= data_in[TONE_BITS-9:0];
                if (addr_reg == A_AMP) amp_reg                 <= data_in[4:0];
            end
        end

        assign tone_period[gi*TONE_BITS +: TONE_BITS] = tone_reg;
        assign amplitude[gi*4 +: 4]                   = amp_reg[3:0];
        assign env_mode[gi]                           = amp_reg[4];
`ifdef READBACK_EN
        assign tone_q[gi] = tone_reg;
        assign amp_q[gi]  = amp_reg;
`endif
    end

    assign noise_period     = noise_reg;
    assign tone_disable     = mixer_reg[N-1:0];
    assign noise_disable    = mixer_reg[2*N-1:N];
    assign envelope_period  = env_reg;
    assign envelope_shape   = shape_reg;
    assign envelope_restart = restart_reg;

`ifdef READBACK_EN
    logic [7:0] rd_data;
    logic [7:0] data_out_reg;
    logic       data_oe_reg;

    // Unmapped addresses fall through to zero.
    always_comb begin
        rd_data = 8'h00;
        if (addr_reg == A_NOISE)  rd_data = 8'(noise_reg);
        if (addr_reg == A_MIXER)  rd_data = 8'(mixer_reg);
        if (addr_reg == A_ENV_LO) rd_data = env_reg[7:0];
        if (addr_reg == A_ENV_HI) rd_data = 8'(env_reg[ENV_BITS-1:8]);
        if (addr_reg == A_SHAPE)  rd_data = 8'(shape_reg);
        for (int c = 0; c < N; c++) begin
            if (addr_reg == ADDR_BITS'(reg_tone_lo(c)))  rd_data = tone_q[c][7:0];
            if (addr_reg == ADDR_BITS'(reg_tone_hi(c)))  rd_data = 8'(tone_q[c][TONE_BITS-1:8]);
            if (addr_reg == ADDR_BITS'(reg_amp(N, c)))   rd_data = 8'(amp_q[c]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_out_reg <= 8'h00;
            data_oe_reg  <= 1'b0;
        end else begin
            data_out_reg <= read_en ? rd_data : 8'h00;
            data_oe_reg  <= read_en;
        end
    end

    assign data_out = data_out_reg;
    assign data_oe  = data_oe_reg;
`else
    assign data_out = 8'h00;
    assign data_oe  = 1'b0;
`endif

endmodule
